req_ack_responder: RTL



---
 rtl/resp_pkg.sv | 20 ++
 rtl/resp_fifo.sv | 76 +++++++
 rtl/req_ack_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : resp_pkg
//  Description : Shared constants and helpers for the request/acknowledge
//                responder and its response buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package resp_pkg;

    // Smallest legal pipeline latency and buffer depth
    localparam int c_min_latency = 1;
    localparam int c_min_depth   = 1;

    // Width of a counter that must hold every value from 0 to depth
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : resp_fifo
//  Description : Synchronous FIFO with registered occupancy. The head word
//                becomes visible on rd_data the cycle after it is written.
//                Reads on an empty FIFO are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo
    import resp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = cnt_w(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_rd;

    assign w_do_rd = rd_en && (r_count != '0);

    // Storage array: written at the write pointer, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy tracks writes minus reads; simultaneous ones cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({wr_en, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign empty   = (r_count == '0);
    assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/req_ack_responder.sv
`default_nettype none
// ============================================================================
//  Module      : req_ack_responder
//  Description : Responder end of the valid/ready request/acknowledge link.
//                Accepted tags travel through a LATENCY-1 stage delay line
//                into a response FIFO and are returned in order. A credit
//                counter caps outstanding requests at DEPTH, so the delay
//                line never stalls and the FIFO never overflows.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_ack_responder
    import resp_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       ack_valid,
    input  logic                       ack_ready,
    output logic [TAG_W-1:0]           ack_tag,
    output logic [cnt_w(DEPTH)-1:0]    outstanding
);

    localparam int c_cnt_w = cnt_w(DEPTH);

    // Parameter legality is checked at elaboration
    if (LATENCY < c_min_latency) begin : g_bad_latency
        $fatal(1, "req_ack_responder: LATENCY must be >= 1");
    end
    if (DEPTH < c_min_depth) begin : g_bad_depth
        $fatal(1, "req_ack_responder: DEPTH must be >= 1");
    end

    logic               r_rst_q;
    logic [c_cnt_w-1:0] r_outstanding;
    logic               w_accept;
    logic               w_ack_hs;
    logic               w_dl_vld;
    logic [TAG_W-1:0]   w_dl_tag;
    logic               w_fifo_empty;
    logic [TAG_W-1:0]   w_fifo_rd_data;
    logic [c_cnt_w-1:0] w_fifo_count;

    // Delayed reset keeps req_ready low for the cycle following reset
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    // Ready depends on registers only: no input-to-output path
    assign req_ready = !r_rst_q && (r_outstanding < c_cnt_w'(DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_ack_hs  = ack_valid && ack_ready;

    if (LATENCY > 1) begin : g_delay
        logic [LATENCY-2:0] r_vld;
        logic [TAG_W-1:0]   r_tag [LATENCY-1];

        // Free-running shift of accepted tags; valids clear on reset
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_accept;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
            r_tag[0] <= req_tag;
            for (int i = 1; i < LATENCY - 1; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end

        assign w_dl_vld = r_vld[LATENCY-2];
        assign w_dl_tag = r_tag[LATENCY-2];
    end else begin : g_direct
        assign w_dl_vld = w_accept;
        assign w_dl_tag = req_tag;
    end

    resp_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_dl_vld),
        .wr_data (w_dl_tag),
        .rd_en   (w_ack_hs),
        .rd_data (w_fifo_rd_data),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    // Stale buffer contents are masked so ack_tag reads zero when idle
    assign ack_valid = !w_fifo_empty;
    assign ack_tag   = w_fifo_empty ? '0 : w_fifo_rd_data;

    // Credit counter: +1 on accept, -1 on ack, unchanged when both happen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_ack_hs})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding = r_outstanding;

    // Handshake properties expected by the initiator-side checkers
    a_ack_hold : assert property (@(posedge clk) disable iff (rst)
        (ack_valid && !ack_ready) |=> (ack_valid && $stable(ack_tag)))
        else $error("req_ack_responder: ack dropped or changed while stalled");

    a_cnt_range : assert property (@(posedge clk) disable iff (rst)
        (r_outstanding <= c_cnt_w'(DEPTH)))
        else $error("req_ack_responder: outstanding above DEPTH");

    a_no_ack_empty : assert property (@(posedge clk) disable iff (rst)
        !(ack_valid && (r_outstanding == '0)))
        else $error("req_ack_responder: ack with nothing outstanding");

    a_latency : assert property (@(posedge clk) disable iff (rst)
        (w_accept && (r_outstanding == '0)) |-> ##LATENCY ack_valid)
        else $error("req_ack_responder: ack late for idle accept");

    a_buf_credit : assert property (@(posedge clk) disable iff (rst)
        (w_fifo_count <= r_outstanding))
        else $error("req_ack_responder: buffer holds more than outstanding");

endmodule
`default_nettype wire
